// File: rtl/gpu_op_arbiter_pkg.sv
// Shared GPU op definitions plus the types and helpers used by the op-FIFO
// write-port arbiter.
//   gpu_op_t         : one GPU draw/control op as written into the op FIFO
//   arb_state_e      : arbiter FSM state
//   onehot_to_index  : index of the set bit of a one-hot vector (up to 8 bits)
package gpu_op_arbiter_pkg;

  typedef struct packed {
    logic [3:0] opcode;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] color;
  } gpu_op_t;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 8;

  function automatic logic [2:0] onehot_to_index(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gpu_op_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req   : request mask, one bit per requester
//   ptr   : index of the most recently served requester
//   pick  : one-hot winner, first set bit scanning ptr+1, ptr+2, ... mod N
//   found : at least one request was present
module rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic             found
);

  logic [PTR_W-1:0] idx;

  // Wrap by explicit compare so non-power-of-two N is handled correctly.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < N; k++) begin
      idx = (idx == PTR_W'(N - 1)) ? '0 : idx + PTR_W'(1);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpu_op_arbiter.sv
// Round-robin arbiter sharing the single GPU op FIFO write port between
// REQ_COUNT producers. A grant is locked until the owner's op flagged last
// is accepted, so multi-op draws are never interleaved. A watchdog frees a
// lock that sits idle for LOCK_TIMEOUT cycles.
//   clk, rst_n     : clock, asynchronous active-low reset
//   ce             : clock enable for state, counters and rr pointer
//   req_valid/op/last, req_ready : per-requester valid/ready handshake
//   op, op_wr_en, op_full        : registered FIFO write port
//   grant, busy, status_timeout  : owner one-hot, in-GRANT flag, sticky timeout
module gpu_op_arbiter
  import gpu_op_arbiter_pkg::*;
#(
  parameter int REQ_COUNT    = 2,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TIMEOUT_W    = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [REQ_COUNT-1:0] req_valid,
  input  gpu_op_t              req_op [REQ_COUNT],
  input  logic [REQ_COUNT-1:0] req_last,
  output logic [REQ_COUNT-1:0] req_ready,
  output gpu_op_t              op,
  output logic                 op_wr_en,
  input  logic                 op_full,
  output logic [REQ_COUNT-1:0] grant,
  output logic                 busy,
  output logic                 status_timeout
);

  localparam int PTR_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

  arb_state_e           state_q, state_d;
  logic [REQ_COUNT-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TIMEOUT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic                 timeout_q, timeout_d;
  gpu_op_t              op_p1_q, op_p1_d;
  logic                 vld_p1_q, vld_p1_d;

  logic [REQ_COUNT-1:0] pick;
  logic                 pick_found;
  logic                 ready_en;
  logic                 xfer;
  logic                 owner_last;
  logic [PTR_W-1:0]     owner_idx;
  gpu_op_t              owner_op;

  rr_picker #(
    .N     (REQ_COUNT),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .pick  (pick),
    .found (pick_found)
  );

  // Blocking on a pending write keeps op_full current for a registered-full FIFO.
  assign ready_en   = (state_q == ARB_GRANT) && ce && !op_full && !vld_p1_q;
  assign req_ready  = ready_en ? grant_q : '0;
  assign xfer       = |(req_ready & req_valid);
  assign owner_last = |(grant_q & req_last);
  assign owner_idx  = PTR_W'(onehot_to_index(MAX_REQ'(grant_q)));

  always_comb begin
    owner_op = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (grant_q[i]) owner_op = req_op[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    timeout_d  = timeout_q;
    op_p1_d    = op_p1_q;
    vld_p1_d   = 1'b0;

    if (xfer) begin
      op_p1_d  = owner_op;
      vld_p1_d = 1'b1;
    end

    if (ce) begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_d    = pick;
            state_d    = ARB_GRANT;
            idle_cnt_d = '0;
          end
        end
        ARB_GRANT: begin
          if (xfer) begin
            idle_cnt_d = '0;
            if (owner_last) begin
              state_d  = ARB_IDLE;
              rr_ptr_d = owner_idx;
              grant_d  = '0;
            end
          end else if (idle_cnt_q == TIMEOUT_W'(LOCK_TIMEOUT - 1)) begin
            // Stalled lock: release it and charge the turn to the owner.
            state_d   = ARB_IDLE;
            rr_ptr_d  = owner_idx;
            grant_d   = '0;
            timeout_d = 1'b1;
          end else if (idle_cnt_q != '1) begin
            idle_cnt_d = idle_cnt_q + TIMEOUT_W'(1);
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // ---- stage p1: FSM state and registered FIFO write ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= PTR_W'(REQ_COUNT - 1);
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
      op_p1_q    <= '0;
      vld_p1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
      op_p1_q    <= op_p1_d;
      vld_p1_q   <= vld_p1_d;
    end
  end

  assign op             = op_p1_q;
  assign op_wr_en       = vld_p1_q;
  assign grant          = grant_q;
  assign busy           = (state_q == ARB_GRANT);
  assign status_timeout = timeout_q;

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// Directed bench for gpu_op_arbiter: a per-cycle vector table plus
// hand-written sequences for sequence ordering, FIFO-full stall, watchdog
// release and asynchronous reset.
module tb_gpu_op_arbiter;
  import gpu_op_arbiter_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic [1:0] req_valid;
  logic [1:0] req_last;
  gpu_op_t    req_op [2];
  logic       op_full;

  logic [1:0] rdy, grant;
  gpu_op_t    op;
  logic       op_wr_en, busy, st_to;

  logic [1:0] wd_rdy, wd_grant;
  gpu_op_t    wd_op;
  logic       wd_wr, wd_busy, wd_to;

  int total = 0;
  int bad   = 0;

  gpu_op_arbiter #(.REQ_COUNT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .req_valid(req_valid), .req_op(req_op), .req_last(req_last), .req_ready(rdy),
    .op(op), .op_wr_en(op_wr_en), .op_full(op_full),
    .grant(grant), .busy(busy), .status_timeout(st_to)
  );

  gpu_op_arbiter #(.REQ_COUNT(2), .LOCK_TIMEOUT(8)) u_wd (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .req_valid(req_valid), .req_op(req_op), .req_last(req_last), .req_ready(wd_rdy),
    .op(wd_op), .op_wr_en(wd_wr), .op_full(op_full),
    .grant(wd_grant), .busy(wd_busy), .status_timeout(wd_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [1:0] vld;
    logic [1:0] last;
    int         x0;
    int         x1;
    logic       full;
    logic       ce_i;
    logic [1:0] e_grant;
    logic [1:0] e_ready;
    logic       e_wr;
    int         e_x;
    logic       e_busy;
  } vec_t;

  localparam int NV = 21;
  vec_t tv [NV];

  function automatic gpu_op_t mk(input int x);
    gpu_op_t o;
    o.opcode = 4'h1;
    o.x      = 10'(x);
    o.y      = 10'(x + 3);
    o.color  = 8'h5A;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ce        = 1'b1;
    req_valid = '0;
    req_last  = '0;
    op_full   = 1'b0;
    req_op[0] = mk(0);
    req_op[1] = mk(0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  int   cnt0, cnt1, nw, consec;
  logic prev;
  logic [1:0] acc;
  int   wx  [12];
  int   exp_order [12];
  int   wr_seen;

  initial begin
    // vld last x0 x1 full ce | grant ready wr x busy
    tv[0]  = '{2'b01, 2'b01,  5,  0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0,  0, 1'b0};
    tv[1]  = '{2'b01, 2'b01,  5,  0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0,  0, 1'b1};
    tv[2]  = '{2'b00, 2'b00,  5,  0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1,  5, 1'b0};
    tv[3]  = '{2'b00, 2'b00,  5,  0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0,  5, 1'b0};
    tv[4]  = '{2'b10, 2'b00,  0,  9, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0,  5, 1'b0};
    tv[5]  = '{2'b10, 2'b00,  0,  9, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0,  5, 1'b1};
    tv[6]  = '{2'b10, 2'b00,  0, 12, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1,  9, 1'b1};
    tv[7]  = '{2'b10, 2'b00,  0, 12, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0,  9, 1'b1};
    tv[8]  = '{2'b10, 2'b00,  0, 12, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0,  9, 1'b1};
    tv[9]  = '{2'b10, 2'b00,  0, 12, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0,  9, 1'b1};
    tv[10] = '{2'b10, 2'b00,  0, 12, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0,  9, 1'b1};
    tv[11] = '{2'b10, 2'b10,  0, 12, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0,  9, 1'b1};
    tv[12] = '{2'b00, 2'b00,  0,  0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 12, 1'b0};
    tv[13] = '{2'b00, 2'b00,  0,  0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 12, 1'b0};
    tv[14] = '{2'b11, 2'b10, 20, 30, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 12, 1'b0};
    tv[15] = '{2'b11, 2'b10, 20, 30, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 12, 1'b1};
    tv[16] = '{2'b11, 2'b11, 21, 30, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 20, 1'b1};
    tv[17] = '{2'b11, 2'b11, 21, 30, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 20, 1'b1};
    tv[18] = '{2'b10, 2'b10,  0, 30, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 21, 1'b0};
    tv[19] = '{2'b10, 2'b10,  0, 30, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 21, 1'b1};
    tv[20] = '{2'b00, 2'b00,  0,  0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 30, 1'b0};

    exp_order = '{0, 1, 2, 16, 17, 18, 3, 4, 5, 19, 20, 21};

    // Reset values while reset is held.
    rst_n     = 1'b0;
    ce        = 1'b1;
    req_valid = '0;
    req_last  = '0;
    op_full   = 1'b0;
    req_op[0] = mk(0);
    req_op[1] = mk(0);
    #2;
    chk("rst op",      op,       32'h0);
    chk("rst wr",      op_wr_en, 32'h0);
    chk("rst grant",   grant,    32'h0);
    chk("rst busy",    busy,     32'h0);
    chk("rst timeout", st_to,    32'h0);

    // Vector table: single op, ce hold, last on non-owner ignored.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      req_valid = tv[i].vld;
      req_last  = tv[i].last;
      req_op[0] = mk(tv[i].x0);
      req_op[1] = mk(tv[i].x1);
      op_full   = tv[i].full;
      ce        = tv[i].ce_i;
      #1;
      chk($sformatf("v%0d grant", i), grant,    tv[i].e_grant);
      chk($sformatf("v%0d ready", i), rdy,      tv[i].e_ready);
      chk($sformatf("v%0d wr", i),    op_wr_en, tv[i].e_wr);
      chk($sformatf("v%0d x", i),     op.x,     tv[i].e_x);
      chk($sformatf("v%0d busy", i),  busy,     tv[i].e_busy);
      tick();
    end

    // Two requesters, 3-op sequences each, twice: alternate without interleave.
    do_reset();
    cnt0 = 0; cnt1 = 0; nw = 0; consec = 0; prev = 1'b0;
    for (int cyc = 0; cyc < 300 && nw < 12; cyc++) begin
      req_valid[0] = (cnt0 < 6);
      req_valid[1] = (cnt1 < 6);
      req_op[0]    = mk(cnt0);
      req_op[1]    = mk(16 + cnt1);
      req_last[0]  = (cnt0 % 3 == 2);
      req_last[1]  = (cnt1 % 3 == 2);
      #1;
      acc = req_valid & rdy;
      if (op_wr_en) begin
        if (prev) consec++;
        if (nw < 12) wx[nw] = int'(op.x);
        nw++;
      end
      prev = op_wr_en;
      tick();
      if (acc[0]) cnt0++;
      if (acc[1]) cnt1++;
    end
    chk("seq writes", nw, 12);
    chk("seq back-to-back wr", consec, 0);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("seq order %0d", k), wx[k], exp_order[k]);
    end

    // op_full stall during r1's second op.
    do_reset();
    req_valid = 2'b10;
    req_last  = 2'b00;
    req_op[1] = mk(40);
    tick();
    chk("full grant", grant, 2'b10);
    chk("full ready0", rdy, 2'b10);
    tick();
    req_op[1] = mk(41);
    req_last  = 2'b10;
    op_full   = 1'b1;
    #1;
    chk("full wr first", op_wr_en, 1'b1);
    chk("full op first", op, mk(40));
    wr_seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (rdy != 2'b00) chk($sformatf("full stall ready %0d", i), rdy, 2'b00);
      if (op_wr_en) wr_seen++;
    end
    chk("full stall writes", wr_seen, 0);
    chk("full stall grant", grant, 2'b10);
    op_full = 1'b0;
    #1;
    chk("full release ready", rdy, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("full wr second", op_wr_en, 1'b1);
    chk("full op second", op, mk(41));
    chk("full grant after", grant, 2'b00);
    wr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (op_wr_en) wr_seen++;
    end
    chk("full single write", wr_seen, 0);

    // Watchdog on the LOCK_TIMEOUT=8 instance.
    do_reset();
    req_valid = 2'b11;
    req_last  = 2'b10;
    req_op[0] = mk(50);
    req_op[1] = mk(60);
    #1;
    chk("wd idle grant", wd_grant, 2'b00);
    tick();
    chk("wd ready r0", wd_rdy, 2'b01);
    tick();
    req_valid = 2'b10;
    chk("wd wr r0", wd_wr, 1'b1);
    chk("wd x r0", wd_op.x, 50);
    repeat (7) tick();
    chk("wd no timeout yet", wd_to, 1'b0);
    chk("wd still locked", wd_grant, 2'b01);
    tick();
    chk("wd timeout set", wd_to, 1'b1);
    chk("wd grant released", wd_grant, 2'b00);
    chk("wd busy released", wd_busy, 1'b0);
    tick();
    chk("wd grant r1", wd_grant, 2'b10);
    chk("wd ready r1", wd_rdy, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("wd wr r1", wd_wr, 1'b1);
    chk("wd x r1", wd_op.x, 60);
    repeat (3) tick();
    chk("wd timeout sticky", wd_to, 1'b1);
    chk("main no timeout", st_to, 1'b0);

    // Asynchronous reset between accept and write.
    do_reset();
    req_valid = 2'b01;
    req_last  = 2'b01;
    req_op[0] = mk(70);
    tick();
    tick();
    chk("ar wr before", op_wr_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar wr", op_wr_en, 1'b0);
    chk("ar grant", grant, 2'b00);
    chk("ar busy", busy, 1'b0);
    chk("ar op", op, 32'h0);
    req_valid = 2'b11;
    req_last  = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar restart r0", grant, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
